dino_key_scheduler: RTL and testbench



---
 rtl/dino_key_scheduler.sv | 279 +++++++++++++++++++++++++++
 tb/tb_dino_key_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dino_key_scheduler.sv
// -----------------------------------------------------------------------------
// dino_key_scheduler
//
// Turns PS/2 decoder key-change pulses into a filtered stream of game commands
// (START, JUMP, DUCK_ON, DUCK_OFF) for the dino game FSM. Typematic repeats
// from the keyboard are suppressed with per-key held flags. Commands are queued
// in a small FIFO and handed out over a valid/ready handshake.
//
// Optional feature (compile-time macro KEY_REPEAT_EN): while a jump key is held
// the block generates its own JUMP commands, the first REPEAT_DELAY cycles after
// the press and then every REPEAT_PERIOD cycles.
//
// Parameters:
//   FIFO_DEPTH     command FIFO entries (power of two, >= 2)
//   REPEAT_DELAY   cycles from jump press to first auto-repeat JUMP (>= 1)
//   REPEAT_PERIOD  cycles between later auto-repeat JUMPs (>= 1)
//
// Ports:
//   clk          system clock, all state on posedge
//   rst          asynchronous active-low reset
//   key_valid    one-cycle pulse, decoder reports a key change
//   last_change  {extend, scan code} of the changed key
//   key_pressed  1 = make, 0 = break
//   cmd_valid    FIFO head holds a command
//   cmd          head command: 1 START, 2 JUMP, 3 DUCK_ON, 4 DUCK_OFF
//   cmd_ready    consumer accepts the head when cmd_valid = 1
//   fifo_level   current FIFO entry count
//   overflow     sticky, a command was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module dino_key_scheduler #(
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 12_500_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_valid,
    input  logic [8:0]                  last_change,
    input  logic                        key_pressed,
    output logic                        cmd_valid,
    output logic [2:0]                  cmd,
    input  logic                        cmd_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);

    localparam logic [8:0] KEY_ENTER = 9'h05A;
    localparam logic [8:0] KEY_SPACE = 9'h029;
    localparam logic [8:0] KEY_UP    = 9'h075;
    localparam logic [8:0] KEY_DOWN  = 9'h072;

    typedef enum logic [2:0] {
        CMD_NONE     = 3'd0,
        CMD_START    = 3'd1,
        CMD_JUMP     = 3'd2,
        CMD_DUCK_ON  = 3'd3,
        CMD_DUCK_OFF = 3'd4
    } cmd_t;

    // -------------------------------------------------------------------------
    // Key decode and typematic filter
    // -------------------------------------------------------------------------
    logic held_enter, held_space, held_up, held_down;
    logic held_enter_n, held_space_n, held_up_n, held_down_n;
    cmd_t ev_cmd;
    logic jump_press;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        held_enter_n = held_enter;
        held_space_n = held_space;
        held_up_n    = held_up;
        held_down_n  = held_down;
        ev_cmd       = CMD_NONE;
        jump_press   = 1'b0;

        if (key_valid) begin
            case (last_change)
                KEY_ENTER: begin
                    if (!key_pressed) begin
                        held_enter_n = 1'b0;
                    end else if (!held_enter) begin
                        held_enter_n = 1'b1;
                        ev_cmd       = CMD_START;
                    end
                end
                KEY_SPACE: begin
                    if (!key_pressed) begin
                        held_space_n = 1'b0;
                    end else if (!held_space) begin
                        held_space_n = 1'b1;
                        // Space and up share the jump; the second key adds nothing.
                        if (!held_up) begin
                            ev_cmd     = CMD_JUMP;
                            jump_press = 1'b1;
                        end
                    end
                end
                KEY_UP: begin
                    if (!key_pressed) begin
                        held_up_n = 1'b0;
                    end else if (!held_up) begin
                        held_up_n = 1'b1;
                        if (!held_space) begin
                            ev_cmd     = CMD_JUMP;
                            jump_press = 1'b1;
                        end
                    end
                end
                KEY_DOWN: begin
                    if (!key_pressed) begin
                        held_down_n = 1'b0;
                        ev_cmd      = CMD_DUCK_OFF;
                    end else if (!held_down) begin
                        held_down_n = 1'b1;
                        ev_cmd      = CMD_DUCK_ON;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_enter <= 1'b0;
            held_space <= 1'b0;
            held_up    <= 1'b0;
            held_down  <= 1'b0;
        end else begin
            held_enter <= held_enter_n;
            held_space <= held_space_n;
            held_up    <= held_up_n;
            held_down  <= held_down_n;
        end
    end

    // -------------------------------------------------------------------------
    // Jump auto-repeat
    // -------------------------------------------------------------------------
    logic fire;

`ifdef KEY_REPEAT_EN
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    rpt_state_t       rpt_state, rpt_state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    always_comb begin
        rpt_state_n = rpt_state;
        cnt_n       = cnt;
        fire        = 1'b0;

        // Releasing the last jump key cancels the repeat, even a pending fire.
        if (!held_space_n && !held_up_n) begin
            rpt_state_n = RPT_IDLE;
            cnt_n       = '0;
        end else begin
            case (rpt_state)
                RPT_IDLE: begin
                    if (jump_press) begin
                        rpt_state_n = RPT_DELAY;
                        cnt_n       = DELAY_LOAD;
                    end
                end
                RPT_DELAY, RPT_REPEAT: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - CNT_W'(1);
                    end else if (ev_cmd == CMD_NONE) begin
                        // A decoder command owns the single push slot; otherwise
                        // the fire waits here with cnt parked at zero.
                        fire        = 1'b1;
                        rpt_state_n = RPT_REPEAT;
                        cnt_n       = PERIOD_LOAD;
                    end
                end
                default: begin
                    rpt_state_n = RPT_IDLE;
                    cnt_n       = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_state <= RPT_IDLE;
            cnt       <= '0;
        end else begin
            rpt_state <= rpt_state_n;
            cnt       <= cnt_n;
        end
    end
`else
    assign fire = 1'b0;

    // Keeps the repeat-only signal and parameters referenced when the feature
    // is compiled out.
    logic unused_cfg;
    assign unused_cfg = jump_press ^ (REPEAT_DELAY < 1) ^ (REPEAT_PERIOD < 1);
`endif

    // -------------------------------------------------------------------------
    // Command FIFO
    // -------------------------------------------------------------------------
    logic [2:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [2:0]       cmd_hold;
    cmd_t             push_cmd;
    logic             push, pop, full, push_ok;

    always_comb begin
        push_cmd = (ev_cmd != CMD_NONE) ? ev_cmd : CMD_JUMP;
    end

    assign push      = (ev_cmd != CMD_NONE) || fire;
    assign cmd_valid = (fifo_level != '0);
    assign pop       = cmd_valid && cmd_ready;
    assign full      = (fifo_level == FULL_LEVEL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok   = push && (!full || pop);

    // With the FIFO empty the output shows the last head rather than stale
    // storage, which is why cmd_hold exists alongside the memory.
    assign cmd = cmd_valid ? mem[rd_ptr] : cmd_hold;

    // NOTE: the storage array has no reset; entries are only observable after
    // being written, and leaving it out of reset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            cmd_hold   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: ;
            endcase
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (cmd_valid) begin
                cmd_hold <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_dino_key_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dino_key_scheduler
//
// Scoreboard bench for dino_key_scheduler. A reference model driven from the
// key rules (held-key table, absolute fire times for the auto-repeat) pushes
// each accepted command into a queue; a monitor on the falling edge pops the
// queue whenever the DUT hands out a command and compares level, valid,
// overflow and the command value every cycle.
// -----------------------------------------------------------------------------
module tb_dino_key_scheduler;

    localparam int DEPTH  = 4;
    localparam int DELAY  = 8;
    localparam int PERIOD = 4;

    localparam logic [8:0] K_ENTER = 9'h05A;
    localparam logic [8:0] K_SPACE = 9'h029;
    localparam logic [8:0] K_UP    = 9'h075;
    localparam logic [8:0] K_DOWN  = 9'h072;
    localparam logic [8:0] K_OTHER = 9'h01C;

    logic       clk         = 1'b0;
    logic       rst         = 1'b0;
    logic       key_valid   = 1'b0;
    logic [8:0] last_change = '0;
    logic       key_pressed = 1'b0;
    logic       cmd_ready   = 1'b0;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic [2:0] fifo_level;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    dino_key_scheduler #(
        .FIFO_DEPTH    (DEPTH),
        .REPEAT_DELAY  (DELAY),
        .REPEAT_PERIOD (PERIOD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .last_change (last_change),
        .key_pressed (key_pressed),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .cmd_ready   (cmd_ready),
        .fifo_level  (fifo_level),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    logic [2:0] exp_q[$];
    logic [2:0] exp_last;
    bit         held[512];
    int         m_level;
    bit         m_ovf;
    bit         rep_on;
    longint     cyc;
    longint     next_fire;

    task automatic model_reset();
        exp_q.delete();
        exp_last  = '0;
        foreach (held[i]) held[i] = 1'b0;
        m_level   = 0;
        m_ovf     = 1'b0;
        rep_on    = 1'b0;
        next_fire = 0;
    endtask

    task automatic model_step();
        logic [2:0] ev;
        logic [2:0] pc;
        bit         jp;
        bit         fire;
        bit         pop;
        bit         push_ok;
        bit         jump_held;
        ev      = 3'd0;
        jp      = 1'b0;
        fire    = 1'b0;
        push_ok = 1'b0;
        pop     = (m_level != 0) && cmd_ready;

        if (key_valid && (last_change inside {K_ENTER, K_SPACE, K_UP, K_DOWN})) begin
            if (key_pressed) begin
                if (!held[last_change]) begin
                    jump_held = held[K_SPACE] || held[K_UP];
                    held[last_change] = 1'b1;
                    case (last_change)
                        K_ENTER: ev = 3'd1;
                        K_DOWN:  ev = 3'd3;
                        default: if (!jump_held) begin ev = 3'd2; jp = 1'b1; end
                    endcase
                end
            end else begin
                held[last_change] = 1'b0;
                if (last_change == K_DOWN) ev = 3'd4;
            end
        end

`ifdef KEY_REPEAT_EN
        if (!held[K_SPACE] && !held[K_UP]) begin
            rep_on = 1'b0;
        end else if (jp) begin
            rep_on    = 1'b1;
            next_fire = cyc + DELAY;
        end else if (rep_on && cyc >= next_fire && ev == 3'd0) begin
            fire      = 1'b1;
            next_fire = cyc + PERIOD;
        end
`endif

        pc = (ev != 3'd0) ? ev : (fire ? 3'd2 : 3'd0);
        if (pc != 3'd0) begin
            if (m_level < DEPTH || pop) begin
                exp_q.push_back(pc);
                push_ok = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end
        m_level = m_level + int'(push_ok) - int'(pop);
        cyc++;
    endtask

    initial begin
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    // ---------------------------------------------------------------- monitor
    initial begin
        forever begin
            @(negedge clk);
            check("valid", cmd_valid, (m_level != 0));
            check("level", fifo_level, m_level);
            check("overflow", overflow, m_ovf);
            if (cmd_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd", cmd_valid, 1'b0);
                end else begin
                    check("cmd", cmd, exp_q[0]);
                    if (cmd_ready && rst) exp_last = exp_q.pop_front();
                end
            end else begin
                check("cmd_hold", cmd, exp_last);
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [8:0] code, input logic pressed);
        last_change = code;
        key_pressed = pressed;
        key_valid   = 1'b1;
        tick();
        key_valid   = 1'b0;
        last_change = 9'($urandom);
        key_pressed = 1'($urandom);
    endtask

    function automatic logic [8:0] pick_code();
        logic [8:0] codes [6];
        codes[0] = K_ENTER;
        codes[1] = K_SPACE;
        codes[2] = K_UP;
        codes[3] = K_DOWN;
        codes[4] = K_OTHER;
        codes[5] = 9'($urandom);
        return codes[$urandom_range(0, 5)];
    endfunction

    initial begin
        // Events pulsing while held in reset must leave everything at zero.
        send(K_ENTER, 1'b1);
        send(K_SPACE, 1'b1);
        send(K_DOWN, 1'b1);
        check("rst_valid", cmd_valid, 1'b0);
        check("rst_cmd", cmd, 3'd0);
        check("rst_level", fifo_level, 3'd0);
        check("rst_overflow", overflow, 1'b0);
        rst = 1'b1;
        idle(2);

        // One-cycle latency from key_valid to the head.
        send(K_ENTER, 1'b1);
        check("latency_valid", cmd_valid, 1'b1);
        check("latency_cmd", cmd, 3'd1);
        send(K_ENTER, 1'b0);
        cmd_ready = 1'b1;
        idle(2);

        // Typematic repeat of space yields one JUMP; down gives ON then OFF.
        send(K_SPACE, 1'b1);
        send(K_SPACE, 1'b1);
        send(K_SPACE, 1'b0);
        idle(3);
        send(K_DOWN, 1'b1);
        send(K_DOWN, 1'b0);
        idle(3);

        // Overflow: five commands into four entries, then push while popping.
        cmd_ready = 1'b0;
        send(K_DOWN, 1'b1);
        send(K_DOWN, 1'b0);
        send(K_DOWN, 1'b1);
        send(K_DOWN, 1'b0);
        send(K_DOWN, 1'b1);
        check("full_level", fifo_level, 3'd4);
        check("full_overflow", overflow, 1'b1);
        check("full_head", cmd, 3'd3);
        cmd_ready = 1'b1;
        send(K_DOWN, 1'b0);
        check("full_pushpop_level", fifo_level, 3'd4);
        check("full_pushpop_overflow", overflow, 1'b1);
        idle(6);
        check("drained_level", fifo_level, 3'd0);

`ifdef KEY_REPEAT_EN
        // Held 20 cycles: JUMPs at N, N+8, N+12, N+16, N+20.
        send(K_SPACE, 1'b1);
        idle(20);
        send(K_SPACE, 1'b0);
        idle(5);
        // Released at N+10: JUMPs at N and N+8 only.
        send(K_SPACE, 1'b1);
        idle(9);
        send(K_SPACE, 1'b0);
        idle(8);
        // Down press collides with the fire at N+8.
        send(K_SPACE, 1'b1);
        idle(7);
        send(K_DOWN, 1'b1);
        check("collide_duck_on", cmd, 3'd3);
        tick();
        check("collide_jump_late", cmd, 3'd2);
        check("collide_jump_valid", cmd_valid, 1'b1);
        idle(3);
        check("collide_gap", cmd_valid, 1'b0);
        tick();
        check("collide_next_jump", cmd, 3'd2);
        check("collide_next_valid", cmd_valid, 1'b1);
        send(K_SPACE, 1'b0);
        send(K_DOWN, 1'b0);
        idle(4);
`else
        // Without auto-repeat a long hold still gives a single JUMP.
        send(K_SPACE, 1'b1);
        idle(20);
        send(K_SPACE, 1'b0);
        idle(3);
`endif

        // Unmapped code produces nothing.
        send(K_OTHER, 1'b1);
        check("unmapped_level", fifo_level, 3'd0);
        send(K_OTHER, 1'b0);
        idle(2);

        // Randomized traffic with a reset in the middle.
        for (int i = 0; i < 500; i++) begin
            if (i == 250) begin
                rst = 1'b0;
                idle(2);
                rst = 1'b1;
            end
            cmd_ready = ($urandom_range(0, 3) != 0);
            send(pick_code(), 1'($urandom));
            idle($urandom_range(0, 3));
        end

        // Release everything and drain.
        cmd_ready = 1'b1;
        send(K_ENTER, 1'b0);
        send(K_SPACE, 1'b0);
        send(K_UP, 1'b0);
        send(K_DOWN, 1'b0);
        idle(10);
        check("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
